branch_resolve: RTL and testbench

Consumer end of the ALU flag path. Holds the architectural V/N/Z flag register written by the arithmetic and logic units, evaluates the 3-bit branch condition of a branch request against those flags, and returns a taken/not-taken decision plus a 16-bit target to fetch through a one-entry valid/ready output buffer. Sits between the execute stage (flag producers, branch issue) and the PC/fetch logic.

---
 rtl/branch_resolve_pkg.sv | 26 ++
 rtl/branch_resolve_cond.sv | 32 +++
 rtl/branch_resolve.sv | 99 +++++++++
 tb/tb_branch_resolve.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared constants for the branch resolve unit.
// Condition codes, flag bit positions, default widths, buffer states.
package branch_resolve_pkg;

   localparam int PC_W_DEF  = 16;
   localparam int OFF_W_DEF = 9;

   localparam int FLAG_V = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

   localparam logic [2:0] COND_NEQ    = 3'b000;
   localparam logic [2:0] COND_EQ     = 3'b001;
   localparam logic [2:0] COND_GT     = 3'b010;
   localparam logic [2:0] COND_LT     = 3'b011;
   localparam logic [2:0] COND_GTE    = 3'b100;
   localparam logic [2:0] COND_LTE    = 3'b101;
   localparam logic [2:0] COND_OVFL   = 3'b110;
   localparam logic [2:0] COND_UNCOND = 3'b111;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_t;

endpackage

// File: rtl/branch_resolve_cond.sv
// Branch condition evaluator: {V,N,Z} flags + cond code -> take.
// Ports: flags_eff (3), cond (3) in; take (1) out. Purely combinational.
module branch_cond_eval
   import branch_resolve_pkg::*;
(
   input  logic [2:0] flags_eff,
   input  logic [2:0] cond,
   output logic       take
);

   logic v, n, z;

   assign v = flags_eff[FLAG_V];
   assign n = flags_eff[FLAG_N];
   assign z = flags_eff[FLAG_Z];

   always_comb begin
      take = 1'b0;
      unique case (cond)
         COND_NEQ:    take = !z;
         COND_EQ:     take = z;
         COND_GT:     take = !z && !n;
         COND_LT:     take = n;
         COND_GTE:    take = z || !n;
         COND_LTE:    take = n || z;
         COND_OVFL:   take = v;
         COND_UNCOND: take = 1'b1;
         default:     take = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve.sv
// Flag register, branch decision and target, one-entry result buffer.
// Ports: flag write (flag_we, alu_*), branch req (br_*), flush, result (res_*), flags.
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int OFF_W = OFF_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [2:0]      flag_we,
   input  logic            alu_v,
   input  logic            alu_n,
   input  logic            alu_z,
   input  logic            br_valid,
   output logic            br_ready,
   input  logic [2:0]      br_cond,
   input  logic            br_is_reg,
   input  logic [PC_W-1:0] br_pc,
   input  logic [OFF_W-1:0] br_offset,
   input  logic [PC_W-1:0] br_reg,
   input  logic            flush,
   output logic            res_valid,
   input  logic            res_ready,
   output logic            res_taken,
   output logic [PC_W-1:0] res_target,
   output logic [2:0]      flags
);

   logic [2:0]      flag_q;
   logic [2:0]      flag_in;
   logic [2:0]      flag_eff;
   logic            take;
   logic            accept;
   logic [PC_W-1:0] seq_pc;
   logic [PC_W-1:0] off_ext;
   logic [PC_W-1:0] tgt;
   buf_state_t      state_q;
   buf_state_t      state_d;

   // Same-cycle flag writes are forwarded into the condition check.
   assign flag_in  = {alu_v, alu_n, alu_z};
   assign flag_eff = (flag_in & flag_we) | (flag_q & ~flag_we);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flag_q <= 3'b000;
      else        flag_q <= flag_eff;
   end

   assign flags = flag_q;

   branch_cond_eval u_cond (
      .flags_eff (flag_eff),
      .cond      (br_cond),
      .take      (take)
   );

   // Adds wrap modulo 2^PC_W.
   assign seq_pc  = br_pc + PC_W'(1);
   assign off_ext = {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};

   always_comb begin
      tgt = seq_pc;
      if (take) tgt = br_is_reg ? br_reg : seq_pc + off_ext;
   end

   assign br_ready = !flush && (!res_valid || res_ready);
   assign accept   = br_valid && br_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= BUF_EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush)
         state_d = BUF_EMPTY;
      else if (accept)
         state_d = BUF_FULL;
      else if (state_q == BUF_FULL && res_ready)
         state_d = BUF_EMPTY;
   end

   always_comb begin
      res_valid = (state_q == BUF_FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_taken  <= 1'b0;
         res_target <= '0;
      end else if (accept) begin
         res_taken  <= take;
         res_target <= tgt;
      end
   end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve.
// Vector table for decisions/targets, directed runs for stall, flush, reset.
module tb_branch_resolve;

   logic        clk;
   logic        rst_n;
   logic [2:0]  flag_we;
   logic        alu_v, alu_n, alu_z;
   logic        br_valid;
   logic        br_ready;
   logic [2:0]  br_cond;
   logic        br_is_reg;
   logic [15:0] br_pc;
   logic [8:0]  br_offset;
   logic [15:0] br_reg;
   logic        flush;
   logic        res_valid;
   logic        res_ready;
   logic        res_taken;
   logic [15:0] res_target;
   logic [2:0]  flags;

   int errors = 0;
   int checks = 0;

   logic [15:0] seen_q[$];

   branch_resolve dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flag_we    (flag_we),
      .alu_v      (alu_v),
      .alu_n      (alu_n),
      .alu_z      (alu_z),
      .br_valid   (br_valid),
      .br_ready   (br_ready),
      .br_cond    (br_cond),
      .br_is_reg  (br_is_reg),
      .br_pc      (br_pc),
      .br_offset  (br_offset),
      .br_reg     (br_reg),
      .flush      (flush),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_taken  (res_taken),
      .res_target (res_target),
      .flags      (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Records every result the consumer takes.
   always @(posedge clk)
      if (rst_n && res_valid && res_ready) seen_q.push_back(res_target);

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      flag_we   = 3'b000;
      alu_v     = 1'b0;
      alu_n     = 1'b0;
      alu_z     = 1'b0;
      br_valid  = 1'b0;
      br_cond   = 3'b000;
      br_is_reg = 1'b0;
      br_pc     = 16'h0;
      br_offset = 9'h0;
      br_reg    = 16'h0;
      flush     = 1'b0;
   endtask

   task automatic req(input logic [2:0] c, input logic [15:0] pc,
                      input logic [8:0] off);
      br_valid  = 1'b1;
      br_cond   = c;
      br_is_reg = 1'b0;
      br_pc     = pc;
      br_offset = off;
   endtask

   typedef struct {
      logic [2:0]  we;
      logic        v, n, z;
      logic [2:0]  cond;
      logic        is_reg;
      logic [15:0] pc;
      logic [8:0]  off;
      logic [15:0] rg;
      logic        exp_tk;
      logic [15:0] exp_tg;
      logic [2:0]  exp_fl;
   } vec_t;

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{3'b111, 0,0,1, 3'b001, 0, 16'h0010, 9'h005, 16'h0,    1, 16'h0016, 3'b001};
      tbl[1]  = '{3'b111, 0,1,0, 3'b111, 0, 16'h0100, 9'h000, 16'h0,    1, 16'h0101, 3'b010};
      tbl[2]  = '{3'b001, 1,0,0, 3'b011, 0, 16'h0020, 9'h010, 16'h0,    1, 16'h0031, 3'b010};
      tbl[3]  = '{3'b000, 0,0,0, 3'b010, 0, 16'h0040, 9'h010, 16'h0,    0, 16'h0041, 3'b010};
      tbl[4]  = '{3'b000, 0,0,0, 3'b000, 0, 16'h0003, 9'h1FC, 16'h0,    1, 16'h0000, 3'b010};
      tbl[5]  = '{3'b000, 0,0,0, 3'b001, 0, 16'hFFFF, 9'h000, 16'h0,    0, 16'h0000, 3'b010};
      tbl[6]  = '{3'b100, 1,0,0, 3'b110, 0, 16'h0200, 9'h0FF, 16'h0,    1, 16'h0300, 3'b110};
      tbl[7]  = '{3'b000, 0,0,0, 3'b100, 0, 16'h0300, 9'h004, 16'h0,    0, 16'h0301, 3'b110};
      tbl[8]  = '{3'b000, 0,0,0, 3'b101, 1, 16'h0400, 9'h004, 16'hBEEF, 1, 16'hBEEF, 3'b110};
      tbl[9]  = '{3'b011, 0,0,1, 3'b100, 0, 16'h1000, 9'h100, 16'h0,    1, 16'h0F01, 3'b101};
      tbl[10] = '{3'b000, 0,0,0, 3'b010, 0, 16'h7FFF, 9'h020, 16'h0,    0, 16'h8000, 3'b101};
      tbl[11] = '{3'b001, 0,0,0, 3'b010, 0, 16'h0050, 9'h002, 16'h0,    1, 16'h0053, 3'b100};

      idle();
      res_ready = 1'b1;
      rst_n     = 1'b0;
      #12;
      chk("rst_valid",  res_valid,  0);
      chk("rst_taken",  res_taken,  0);
      chk("rst_target", res_target, 0);
      chk("rst_flags",  flags,      0);
      chk("rst_ready",  br_ready,   1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         idle();
         flag_we   = tbl[i].we;
         alu_v     = tbl[i].v;
         alu_n     = tbl[i].n;
         alu_z     = tbl[i].z;
         br_valid  = 1'b1;
         br_cond   = tbl[i].cond;
         br_is_reg = tbl[i].is_reg;
         br_pc     = tbl[i].pc;
         br_offset = tbl[i].off;
         br_reg    = tbl[i].rg;
         #1;
         chk($sformatf("v%0d_ready", i), br_ready, 1);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_valid", i), res_valid, 1);
         chk($sformatf("v%0d_taken", i), res_taken, tbl[i].exp_tk);
         chk($sformatf("v%0d_target", i), res_target, tbl[i].exp_tg);
         chk($sformatf("v%0d_flags", i), flags, tbl[i].exp_fl);
      end

      // Drain, then back-pressure with a pending request.
      @(negedge clk);
      idle();
      @(posedge clk);
      #1;
      chk("drain_valid", res_valid, 0);
      @(negedge clk);
      seen_q.delete();
      res_ready = 1'b0;
      req(3'b111, 16'h0A00, 9'h000);
      @(posedge clk);
      #1;
      chk("bp_a_target", res_target, 16'h0A01);
      @(negedge clk);
      req(3'b111, 16'h0B00, 9'h000);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp_ready_%0d", k), br_ready, 0);
         @(posedge clk);
         #1;
         chk($sformatf("bp_valid_%0d", k), res_valid, 1);
         chk($sformatf("bp_hold_%0d", k), res_target, 16'h0A01);
         @(negedge clk);
      end
      res_ready = 1'b1;
      #1;
      chk("bp_release_ready", br_ready, 1);
      @(posedge clk);
      #1;
      chk("bp_b_target", res_target, 16'h0B01);
      @(negedge clk);
      req(3'b111, 16'h0C00, 9'h000);
      @(posedge clk);
      #1;
      chk("bp_c_target", res_target, 16'h0C01);
      @(negedge clk);
      idle();
      @(posedge clk);
      #1;
      chk("bp_empty", res_valid, 0);
      chk("bp_count", seen_q.size(), 3);
      if (seen_q.size() == 3) begin
         chk("bp_seen0", seen_q[0], 16'h0A01);
         chk("bp_seen1", seen_q[1], 16'h0B01);
         chk("bp_seen2", seen_q[2], 16'h0C01);
      end

      // Flush while full with a concurrent request and flag write.
      @(negedge clk);
      req(3'b111, 16'h0D00, 9'h000);
      @(posedge clk);
      #1;
      chk("fl_pre_valid", res_valid, 1);
      @(negedge clk);
      res_ready = 1'b0;
      flush     = 1'b1;
      flag_we   = 3'b111;
      alu_v     = 1'b1;
      alu_n     = 1'b1;
      alu_z     = 1'b1;
      req(3'b111, 16'h0E00, 9'h000);
      #1;
      chk("fl_ready", br_ready, 0);
      @(posedge clk);
      #1;
      chk("fl_valid", res_valid, 0);
      chk("fl_flags", flags, 3'b111);
      @(negedge clk);
      idle();
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("fl_after_valid", res_valid, 0);

      // Async reset mid-cycle while full.
      @(negedge clk);
      req(3'b111, 16'h0F00, 9'h010);
      @(posedge clk);
      #1;
      chk("ar_pre_target", res_target, 16'h0F11);
      @(negedge clk);
      idle();
      res_ready = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_valid",  res_valid,  0);
      chk("ar_taken",  res_taken,  0);
      chk("ar_target", res_target, 0);
      chk("ar_flags",  flags,      0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ar_stay_empty", res_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
